// File: rtl/decode_ctrl_pipe.sv
// Vector ASIP decode stage: field split, opcode decode, immediate extension and the ID/EX pipe register.
// Optional DECODE_FLUSH_EN adds flush_i, which loads a bubble into the ID/EX pipe.
module decode_ctrl_pipe #(
  parameter int N = 32,
  parameter int V = 20,
  parameter int L = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enable_i,
`ifdef DECODE_FLUSH_EN
  input  logic             flush_i,
`endif
  input  logic [N-1:0]     instruction_i,
  input  logic [N-1:0]     RD1_S_i,
  input  logic [N-1:0]     RD2_S_i,
  input  logic [V*L-1:0]   RD1_V_i,
  input  logic [V*L-1:0]   RD2_V_i,
  input  logic             Mem_Finished_i,
  input  logic             Exe_Finished_i,
  output logic [4:0]       A1_o,
  output logic [4:0]       A2_o,
  output logic             Finished_o,
  output logic [N-1:0]     RD1_S_o,
  output logic [N-1:0]     RD2_S_o,
  output logic [N-1:0]     Extend_o,
  output logic [V*L-1:0]   RD1_V_o,
  output logic [V*L-1:0]   RD2_V_o,
  output logic [4:0]       A3_o,
  output logic             RegFile_WE_o,
  output logic             ALUSource_o,
  output logic             SetFlags_o,
  output logic             MemWE_o,
  output logic             WBSelect_o,
  output logic             OpSource_o,
  output logic [1:0]       ALUControl_o,
  output logic [1:0]       BranchSelect_o,
  output logic [1:0]       OpType_o
);

  typedef struct packed {
    logic       we;
    logic       alu_src;
    logic       set_flags;
    logic       mem_we;
    logic       wb_sel;
    logic       op_src;
    logic [1:0] alu_ctrl;
    logic [1:0] branch;
    logic [1:0] op_type;
  } ctrl_t;

  function automatic logic [N-1:0] extend_imm(input logic [12:0] imm, input logic [1:0] sel);
    logic [N-1:0] zext;
    zext = {{(N-13){1'b0}}, imm};
    case (sel)
      2'b00:   return zext;
      2'b01:   return {{(N-13){imm[12]}}, imm};
      2'b10:   return zext << 13;
      default: return '0;
    endcase
  endfunction

  logic [3:0]   op_p0;
  logic [12:0]  imm_p0;
  logic [1:0]   ext_sel_p0;
  ctrl_t        ctrl_p0;

  ctrl_t        ctrl_p1;
  logic [N-1:0] rd1_s_p1, rd2_s_p1, ext_p1;
  logic [V*L-1:0] rd1_v_p1, rd2_v_p1;
  logic [4:0]   a3_p1;

  assign op_p0      = instruction_i[31:28];
  assign imm_p0     = instruction_i[12:0];
  assign A1_o       = instruction_i[22:18];
  assign A2_o       = instruction_i[17:13];
  assign Finished_o = (op_p0 == 4'b1111) && Mem_Finished_i && Exe_Finished_i;

  // Stage p0: opcode decode (combinational)
  always_comb begin
    ctrl_p0    = '0;
    ext_sel_p0 = 2'b00;
    case (op_p0)
      4'b0001: ctrl_p0.we = 1'b1;
      4'b0010: begin ctrl_p0.we = 1'b1; ctrl_p0.alu_ctrl = 2'b01; end
      4'b0011: begin ctrl_p0.we = 1'b1; ctrl_p0.alu_src = 1'b1; end
      4'b0100: begin ctrl_p0.we = 1'b1; ctrl_p0.alu_src = 1'b1; ctrl_p0.alu_ctrl = 2'b01; end
      4'b0101: begin ctrl_p0.we = 1'b1; ctrl_p0.op_type = 2'b01; end
      4'b0110: begin ctrl_p0.we = 1'b1; ctrl_p0.op_type = 2'b01; ctrl_p0.alu_ctrl = 2'b01; end
      4'b0111: begin ctrl_p0.set_flags = 1'b1; ctrl_p0.alu_ctrl = 2'b01; end
      4'b1000: begin
        ctrl_p0.we = 1'b1; ctrl_p0.alu_src = 1'b1; ctrl_p0.wb_sel = 1'b1; ext_sel_p0 = 2'b01;
      end
      4'b1001: begin ctrl_p0.mem_we = 1'b1; ctrl_p0.alu_src = 1'b1; ext_sel_p0 = 2'b01; end
      4'b1010: begin ctrl_p0.we = 1'b1; ctrl_p0.alu_ctrl = 2'b11; end
      4'b1011: begin
        ctrl_p0.we = 1'b1; ctrl_p0.alu_src = 1'b1; ctrl_p0.wb_sel = 1'b1;
        ctrl_p0.op_src = 1'b1; ctrl_p0.op_type = 2'b01; ext_sel_p0 = 2'b01;
      end
      4'b1100: begin
        ctrl_p0.mem_we = 1'b1; ctrl_p0.alu_src = 1'b1; ctrl_p0.op_src = 1'b1;
        ctrl_p0.op_type = 2'b01; ext_sel_p0 = 2'b01;
      end
      4'b1101: begin ctrl_p0.branch = 2'b01; ext_sel_p0 = 2'b01; end
      4'b1110: begin ctrl_p0.branch = 2'b10; ext_sel_p0 = 2'b01; end
      default: ctrl_p0 = '0;
    endcase
  end

  // Stage p1: ID/EX pipe register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ctrl_p1  <= '0;
      rd1_s_p1 <= '0;
      rd2_s_p1 <= '0;
      ext_p1   <= '0;
      rd1_v_p1 <= '0;
      rd2_v_p1 <= '0;
      a3_p1    <= '0;
`ifdef DECODE_FLUSH_EN
    end else if (flush_i) begin
      ctrl_p1  <= '0;
      rd1_s_p1 <= '0;
      rd2_s_p1 <= '0;
      ext_p1   <= '0;
      rd1_v_p1 <= '0;
      rd2_v_p1 <= '0;
      a3_p1    <= '0;
`endif
    end else if (enable_i) begin
      ctrl_p1  <= ctrl_p0;
      rd1_s_p1 <= RD1_S_i;
      rd2_s_p1 <= RD2_S_i;
      ext_p1   <= extend_imm(imm_p0, ext_sel_p0);
      rd1_v_p1 <= RD1_V_i;
      rd2_v_p1 <= RD2_V_i;
      a3_p1    <= instruction_i[27:23];
    end
  end

  assign RD1_S_o        = rd1_s_p1;
  assign RD2_S_o        = rd2_s_p1;
  assign Extend_o       = ext_p1;
  assign RD1_V_o        = rd1_v_p1;
  assign RD2_V_o        = rd2_v_p1;
  assign A3_o           = a3_p1;
  assign RegFile_WE_o   = ctrl_p1.we;
  assign ALUSource_o    = ctrl_p1.alu_src;
  assign SetFlags_o     = ctrl_p1.set_flags;
  assign MemWE_o        = ctrl_p1.mem_we;
  assign WBSelect_o     = ctrl_p1.wb_sel;
  assign OpSource_o     = ctrl_p1.op_src;
  assign ALUControl_o   = ctrl_p1.alu_ctrl;
  assign BranchSelect_o = ctrl_p1.branch;
  assign OpType_o       = ctrl_p1.op_type;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed self-checking bench for decode_ctrl_pipe (flush scenario built only with DECODE_FLUSH_EN).
module tb_decode_ctrl_pipe;
  localparam int N = 32;
  localparam int V = 20;
  localparam int L = 8;

  logic CLK = 1'b0;
  logic RST, enable_i, Mem_Finished_i, Exe_Finished_i;
`ifdef DECODE_FLUSH_EN
  logic flush_i;
`endif
  logic [N-1:0] instruction_i, RD1_S_i, RD2_S_i;
  logic [V*L-1:0] RD1_V_i, RD2_V_i;
  logic [4:0] A1_o, A2_o, A3_o;
  logic Finished_o;
  logic [N-1:0] RD1_S_o, RD2_S_o, Extend_o;
  logic [V*L-1:0] RD1_V_o, RD2_V_o;
  logic RegFile_WE_o, ALUSource_o, SetFlags_o, MemWE_o, WBSelect_o, OpSource_o;
  logic [1:0] ALUControl_o, BranchSelect_o, OpType_o;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  decode_ctrl_pipe #(.N(N), .V(V), .L(L)) dut (
    .CLK(CLK), .RST(RST), .enable_i(enable_i),
`ifdef DECODE_FLUSH_EN
    .flush_i(flush_i),
`endif
    .instruction_i(instruction_i), .RD1_S_i(RD1_S_i), .RD2_S_i(RD2_S_i),
    .RD1_V_i(RD1_V_i), .RD2_V_i(RD2_V_i),
    .Mem_Finished_i(Mem_Finished_i), .Exe_Finished_i(Exe_Finished_i),
    .A1_o(A1_o), .A2_o(A2_o), .Finished_o(Finished_o),
    .RD1_S_o(RD1_S_o), .RD2_S_o(RD2_S_o), .Extend_o(Extend_o),
    .RD1_V_o(RD1_V_o), .RD2_V_o(RD2_V_o), .A3_o(A3_o),
    .RegFile_WE_o(RegFile_WE_o), .ALUSource_o(ALUSource_o), .SetFlags_o(SetFlags_o),
    .MemWE_o(MemWE_o), .WBSelect_o(WBSelect_o), .OpSource_o(OpSource_o),
    .ALUControl_o(ALUControl_o), .BranchSelect_o(BranchSelect_o), .OpType_o(OpType_o)
  );

  // control outputs packed {WE,ALUSrc,SetFlags,MemWE,WBSel,OpSrc,ALUC,Branch,OpType}
  function automatic logic [11:0] ctrl_now();
    return {RegFile_WE_o, ALUSource_o, SetFlags_o, MemWE_o, WBSelect_o, OpSource_o,
            ALUControl_o, BranchSelect_o, OpType_o};
  endfunction

  function automatic logic [N-1:0] mk(input logic [3:0] op, input logic [4:0] a3,
                                      input logic [4:0] a1, input logic [4:0] a2,
                                      input logic [12:0] imm);
    return {op, a3, a1, a2, imm};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; enable_i = 1'b1; instruction_i = mk(4'b0001, 5'd7, 5'd1, 5'd2, 13'h0123);
    RD1_S_i = 32'hDEADBEEF; RD2_S_i = 32'h12345678;
    RD1_V_i = {V{8'hA5}}; RD2_V_i = {V{8'h3C}};
    Mem_Finished_i = 1'b0; Exe_Finished_i = 1'b0;
    tick();
    total++;
    if ({ctrl_now(), A3_o, RD1_S_o, RD2_S_o, Extend_o} !== '0 || {RD1_V_o, RD2_V_o} !== '0) begin
      bad++; $display("FAIL reset_init: ctrl=%h a3=%0d rd1=%h", ctrl_now(), A3_o, RD1_S_o);
    end
    RST = 1'b0;
    tick();
    total++;
    if (RD1_S_o !== 32'hDEADBEEF || A3_o !== 5'd7 || ctrl_now() !== 12'h800) begin
      bad++; $display("FAIL reset_load: rd1=%h a3=%0d ctrl=%h want deadbeef 7 800", RD1_S_o, A3_o, ctrl_now());
    end
    // asynchronous reset mid-cycle, with an END pending to watch Finished_o
    instruction_i = mk(4'b1111, 5'd0, 5'd0, 5'd0, 13'd0);
    Mem_Finished_i = 1'b1; Exe_Finished_i = 1'b1;
    #2 RST = 1'b1;
    #1;
    total++;
    if ({ctrl_now(), A3_o, RD1_S_o, RD2_S_o, Extend_o} !== '0 || {RD1_V_o, RD2_V_o} !== '0) begin
      bad++; $display("FAIL reset_async: ctrl=%h a3=%0d rd1=%h rd2=%h want 0", ctrl_now(), A3_o, RD1_S_o, RD2_S_o);
    end
    total++;
    if (Finished_o !== 1'b1) begin
      bad++; $display("FAIL reset_finished: got %b want 1", Finished_o);
    end
    tick();
    RST = 1'b0;
    Mem_Finished_i = 1'b0; Exe_Finished_i = 1'b0;
  endtask

  task automatic test_mov_sweep();
    enable_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      instruction_i = mk(4'b1010, 5'd3, 5'(k), 5'd0, 13'd0);
      RD1_S_i = 32'(k);
      #1;
      total++;
      if (A1_o !== 5'(k)) begin
        bad++; $display("FAIL mov_a1 k=%0d: got %0d want %0d", k, A1_o, k);
      end
      tick();
      total++;
      if (RD1_S_o !== 32'(k) || RegFile_WE_o !== 1'b1 || ALUControl_o !== 2'b11 || A3_o !== 5'd3) begin
        bad++; $display("FAIL mov_ex k=%0d: rd1=%h we=%b aluc=%b a3=%0d", k, RD1_S_o, RegFile_WE_o, ALUControl_o, A3_o);
      end
    end
  endtask

  task automatic test_extend();
    logic [3:0]  ops [3] = '{4'b0011, 4'b1000, 4'b1000};
    logic [12:0] imms[3] = '{13'h1FFF, 13'h1FFF, 13'h0FFF};
    logic [N-1:0] exp[3] = '{32'h00001FFF, 32'hFFFFFFFF, 32'h00000FFF};
    enable_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instruction_i = mk(ops[i], 5'd9, 5'd4, 5'd5, imms[i]);
      tick();
      total++;
      if (Extend_o !== exp[i]) begin
        bad++; $display("FAIL extend_%0d: got %h want %h", i, Extend_o, exp[i]);
      end
    end
  endtask

  task automatic test_decode_table();
    logic [11:0] exp_ctrl[16] = '{12'h000, 12'h800, 12'h810, 12'hC00, 12'hC10, 12'h801, 12'h811, 12'h210,
                                  12'hC80, 12'h500, 12'h830, 12'hCC1, 12'h541, 12'h004, 12'h008, 12'h000};
    logic        sext[16] = '{0,0,0,0,0,0,0,0, 1,1,0,1,1,1,1,0};
    logic [N-1:0] exp_ext;
    enable_i = 1'b1;
    for (int op = 0; op < 16; op++) begin
      instruction_i = mk(4'(op), 5'(op + 8), 5'd1, 5'd2, 13'h1000);
      RD2_S_i = 32'hC0DE0000 + 32'(op);
      RD1_V_i = {V{8'(op * 17)}};
      RD2_V_i = {V{8'(8'hF0 - op)}};
      tick();
      exp_ext = sext[op] ? 32'hFFFFF000 : 32'h00001000;
      total++;
      if (ctrl_now() !== exp_ctrl[op] || Extend_o !== exp_ext) begin
        bad++; $display("FAIL decode op=%0d: ctrl=%h ext=%h want %h %h", op, ctrl_now(), Extend_o, exp_ctrl[op], exp_ext);
      end
      total++;
      if (RD2_S_o !== 32'hC0DE0000 + 32'(op) || RD1_V_o !== {V{8'(op * 17)}} ||
          RD2_V_o !== {V{8'(8'hF0 - op)}} || A3_o !== 5'(op + 8)) begin
        bad++; $display("FAIL datapath op=%0d: rd2=%h a3=%0d v1=%h", op, RD2_S_o, A3_o, RD1_V_o);
      end
    end
  endtask

  task automatic test_hold();
    enable_i = 1'b1;
    instruction_i = mk(4'b0100, 5'd21, 5'd6, 5'd7, 13'h0055);
    RD1_S_i = 32'h11112222;
    tick();
    enable_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      instruction_i = mk(4'(c + 5), 5'(c), 5'(c + 10), 5'd0, 13'h1ABC);
      RD1_S_i = 32'(c);
      #1;
      total++;
      if (A1_o !== 5'(c + 10)) begin
        bad++; $display("FAIL hold_a1 c=%0d: got %0d want %0d", c, A1_o, c + 10);
      end
      tick();
      total++;
      if (ctrl_now() !== 12'hC10 || A3_o !== 5'd21 || Extend_o !== 32'h55 || RD1_S_o !== 32'h11112222) begin
        bad++; $display("FAIL hold c=%0d: ctrl=%h a3=%0d ext=%h rd1=%h", c, ctrl_now(), A3_o, Extend_o, RD1_S_o);
      end
    end
    enable_i = 1'b1;
  endtask

  task automatic test_finished();
    logic [3:0] ops[4] = '{4'b1111, 4'b1111, 4'b1111, 4'b0001};
    logic       mem[4] = '{1, 1, 0, 1};
    logic       exe[4] = '{0, 1, 1, 1};
    logic       exp[4] = '{0, 1, 0, 0};
    for (int i = 0; i < 4; i++) begin
      instruction_i = mk(ops[i], 5'd0, 5'd0, 5'd0, 13'd0);
      Mem_Finished_i = mem[i]; Exe_Finished_i = exe[i];
      #1;
      total++;
      if (Finished_o !== exp[i]) begin
        bad++; $display("FAIL finished_%0d: got %b want %b", i, Finished_o, exp[i]);
      end
    end
    Mem_Finished_i = 1'b0; Exe_Finished_i = 1'b0;
  endtask

`ifdef DECODE_FLUSH_EN
  task automatic test_flush();
    enable_i = 1'b1; flush_i = 1'b0;
    instruction_i = mk(4'b0101, 5'd12, 5'd1, 5'd2, 13'h0777);
    tick();
    flush_i = 1'b1;
    tick();
    total++;
    if ({ctrl_now(), A3_o, RD1_S_o, RD2_S_o, Extend_o} !== '0 || {RD1_V_o, RD2_V_o} !== '0) begin
      bad++; $display("FAIL flush: ctrl=%h a3=%0d ext=%h want 0", ctrl_now(), A3_o, Extend_o);
    end
    flush_i = 1'b0;
  endtask
`endif

  initial begin
`ifdef DECODE_FLUSH_EN
    flush_i = 1'b0;
`endif
    test_reset();
    test_mov_sweep();
    test_extend();
    test_decode_table();
    test_hold();
    test_finished();
`ifdef DECODE_FLUSH_EN
    test_flush();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
